// File: rtl/lsu_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_mem_stage : load/store stage driving a valid/ready data-memory bus    |
// | Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module lsu_mem_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] ReadData,
   output logic             Stall,
   output logic             MisalignErr,
   output logic             bus_valid,
   input  logic             bus_ready,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [WIDTH-1:0] bus_wdata,
   output logic [3:0]       bus_be,
   input  logic             bus_rvalid,
   input  logic [WIDTH-1:0] bus_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
`ifdef LSU_MISALIGN_TRAP_EN
      S_ERR  = 3'd4,
`endif
      S_DONE = 3'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [2:0]       r_f3;
   logic [1:0]       r_off;
   logic             w_req;
   logic             w_is_b;
   logic             w_is_h;
   logic [WIDTH-1:0] w_addr;
   logic [3:0]       w_be;
   logic [WIDTH-1:0] w_wdata;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [WIDTH-1:0] w_ldata;
`ifdef LSU_MISALIGN_TRAP_EN
   logic             w_misalign;
`endif

   assign w_req = MemRead | MemWrite;

   // Funct3[1:0] alone selects the size: 00 byte, 01 half, anything else word.
   always_comb begin
      w_is_b = (Funct3[1:0] == 2'b00);
      w_is_h = (Funct3[1:0] == 2'b01);
      w_addr = ALUResult;
`ifdef LSU_MISALIGN_TRAP_EN
      w_misalign = (w_is_h && ALUResult[0]) ||
                   (!w_is_b && !w_is_h && (ALUResult[1:0] != 2'b00));
`else
      if (w_is_h) begin
         w_addr[0] = 1'b0;
      end else if (!w_is_b) begin
         w_addr[1:0] = 2'b00;
      end
`endif
      if (w_is_b) begin
         w_be    = 4'b0001 << w_addr[1:0];
         w_wdata = {(WIDTH/8){WriteData[7:0]}};
      end else if (w_is_h) begin
         w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {(WIDTH/16){WriteData[15:0]}};
      end else begin
         w_be    = 4'b1111;
         w_wdata = WriteData;
      end
   end

   always_comb begin
      w_byte = bus_rdata[{r_off, 3'b000} +: 8];
      w_half = bus_rdata[{r_off[1], 4'b0000} +: 16];
      case (r_f3)
         3'b000:  w_ldata = {{(WIDTH-8){w_byte[7]}}, w_byte};
         3'b100:  w_ldata = {{(WIDTH-8){1'b0}}, w_byte};
         3'b001:  w_ldata = {{(WIDTH-16){w_half[15]}}, w_half};
         3'b101:  w_ldata = {{(WIDTH-16){1'b0}}, w_half};
         default: w_ldata = bus_rdata;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
               w_next = w_misalign ? S_ERR : S_REQ;
`else
               w_next = S_REQ;
`endif
            end
         end
         S_REQ:   if (bus_ready) w_next = bus_we ? S_DONE : S_WAIT;
         S_WAIT:  if (bus_rvalid) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_f3      <= 3'b000;
         r_off     <= 2'b00;
         ReadData  <= '0;
         bus_valid <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= 4'b0000;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_next == S_REQ) begin
            bus_valid <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {w_addr[WIDTH-1:2], 2'b00};
            bus_wdata <= w_wdata;
            bus_be    <= w_be;
            r_f3      <= Funct3;
            r_off     <= w_addr[1:0];
         end
         if (r_state == S_REQ && bus_ready) begin
            bus_valid <= 1'b0;
         end
         if (r_state == S_WAIT && bus_rvalid) begin
            ReadData <= w_ldata;
         end
      end
   end

   // Combinational so the pipeline freezes in the very cycle the request appears.
`ifdef LSU_MISALIGN_TRAP_EN
   assign Stall       = rst_n && w_req && (r_state != S_DONE) && (r_state != S_ERR);
   assign MisalignErr = (r_state == S_ERR);
`else
   assign Stall       = rst_n && w_req && (r_state != S_DONE);
   assign MisalignErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_mem_stage : scoreboard bench with a randomised bus responder       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  Funct3 = 3'b000;
   logic [31:0] ALUResult = '0, WriteData = '0;
   logic [31:0] ReadData;
   logic        Stall, MisalignErr;
   logic        bus_valid, bus_we;
   logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
   logic [3:0]  bus_be;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit c_trap = 1'b1;
`else
   localparam bit c_trap = 1'b0;
`endif

   lsu_mem_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .MisalignErr(MisalignErr),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } bus_exp_t;
   typedef struct { int rdly; int rvdly; bit load; logic [31:0] rdata; } plan_t;
   typedef struct { int stall; bit err; logic [31:0] rd; } comp_t;

   bus_exp_t    bus_q[$];
   plan_t       plan_q[$];
   comp_t       comp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Load result from the access rules: shift the addressed lane down, mask, extend.
   function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] eff,
                                            input logic [31:0] rdata);
      int          size = sz(f3);
      logic [31:0] mask, v;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (rdata >> (8 * (eff % 4))) & mask;
      if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~mask;
      return v;
   endfunction

   task automatic issue(input bit wr, input bit rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int rdly, input int rvdly);
      int          size = sz(f3);
      bit          mis = (addr % size) != 0;
      logic [31:0] eff = addr - (addr % size);
      bit          load = !wr;
      comp_t       c;
      bus_exp_t    b;
      plan_t       p;
      int          n;
      if (c_trap && mis) begin
         c.stall = 1; c.err = 1'b1; c.rd = model_rd;
      end else begin
         b.addr  = eff & ~32'h3;
         b.be    = 4'(((1 << size) - 1) << (eff % 4));
         b.we    = wr;
         b.wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                   (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
         bus_q.push_back(b);
         p.rdly = rdly; p.rvdly = rvdly; p.load = load; p.rdata = rdat;
         plan_q.push_back(p);
         if (load) model_rd = ext_load(f3, eff, rdat);
         c.stall = 2 + rdly + (load ? rvdly : 0); c.err = 1'b0; c.rd = model_rd;
      end
      comp_q.push_back(c);
      MemWrite = wr; MemRead = rd; Funct3 = f3; ALUResult = addr; WriteData = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (Stall && n < 300);
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL txn_timeout addr=%h stall_still=%b required=0", addr, Stall);
      end
      @(posedge clk); #1;
   endtask

   // Bus slave: inserts the planned ready/rvalid delays for each accepted request.
   initial begin
      plan_t p;
      forever begin
         @(posedge clk); #2;
         if (!(rst_n && bus_valid)) continue;
         if (plan_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_no_plan addr=%h required=no_request", bus_addr);
            continue;
         end
         p = plan_q.pop_front();
         repeat (p.rdly) begin @(posedge clk); #2; end
         bus_ready = 1'b1;
         @(posedge clk); #2;
         bus_ready = 1'b0;
         if (p.load) begin
            repeat (p.rvdly - 1) begin @(posedge clk); #2; end
            bus_rvalid = 1'b1; bus_rdata = p.rdata;
            @(posedge clk); #2;
            bus_rvalid = 1'b0; bus_rdata = $urandom;
         end
      end
   end

   // Request-side monitor: every REQ cycle must present the expected, stable request.
   always @(negedge clk) begin
      bus_exp_t b;
      if (rst_n && bus_valid) begin
         checks++;
         if (bus_q.size() == 0) begin
            failures++;
            $display("FAIL bus_unexpected addr=%h be=%b required=no_request", bus_addr, bus_be);
         end else begin
            b = bus_q[0];
            if (bus_addr !== b.addr || bus_be !== b.be || bus_we !== b.we ||
                (b.we && bus_wdata !== b.wdata)) begin
               failures++;
               $display("FAIL bus_req actual=%h/%b/%b/%h required=%h/%b/%b/%h",
                        bus_addr, bus_be, bus_we, bus_wdata, b.addr, b.be, b.we, b.wdata);
            end
            if (bus_ready) void'(bus_q.pop_front());
         end
      end
   end

   // Completion monitor: request held with Stall low marks DONE or ERR.
   int stall_cnt = 0;
   always @(negedge clk) begin
      comp_t c;
      if (!rst_n) begin
         stall_cnt = 0;
      end else if (Stall) begin
         stall_cnt++;
         if (MisalignErr) begin
            checks++; failures++;
            $display("FAIL err_while_stall actual=1 required=0");
         end
      end else begin
         if (MemRead || MemWrite) begin
            if (comp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL comp_unexpected stall_cycles=%0d required=none", stall_cnt);
            end else begin
               c = comp_q.pop_front();
               chk("stall_cycles", stall_cnt, c.stall);
               chk("misalign_err", {31'd0, MisalignErr}, {31'd0, c.err});
               chk("read_data", ReadData, c.rd);
            end
         end else if (MisalignErr) begin
            checks++; failures++;
            $display("FAIL err_idle actual=1 required=0");
         end
         stall_cnt = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d required=finish", checks);
      $fatal(1);
   end

   initial begin
      int r;
      int g;
      plan_t    p;
      bus_exp_t b;
      MemRead = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_stall", {31'd0, Stall}, 32'd0);
      chk("rst_readdata", ReadData, 32'd0);
      chk("rst_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst_we", {31'd0, bus_we}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_be", {28'd0, bus_be}, 32'd0);
      chk("rst_err", {31'd0, MisalignErr}, 32'd0);
      MemRead = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1);
      issue(0, 1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
      chk("lb_0x103", ReadData, 32'hFFFF_FF80);
      issue(0, 1, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
      chk("lbu_0x103", ReadData, 32'h0000_0080);
      issue(1, 0, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0, 1);
      issue(0, 1, 3'b010, 32'h100, 32'h0, 32'h1357_9BDF, 3, 2);
      chk("lw_backpressure", ReadData, 32'h1357_9BDF);
      MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      issue(0, 1, 3'b010, 32'h101, 32'h0, 32'h2468_ACE0, 0, 1);
      chk("lw_misaligned", ReadData, c_trap ? 32'h1357_9BDF : 32'h2468_ACE0);
      issue(1, 1, 3'b000, 32'h201, 32'h0000_005A, 32'h0, 1, 1);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(1, 3);
         issue(r[0], r[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(1, 3));
         g = $urandom_range(0, 2);
         if (g > 0) begin
            MemRead = 1'b0; MemWrite = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
      end
      MemRead = 1'b0; MemWrite = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Abandon a load in WAIT; its late rvalid must not reach ReadData.
      p.rdly = 0; p.rvdly = 6; p.load = 1'b1; p.rdata = 32'hCAFE_BABE;
      plan_q.push_back(p);
      b.addr = 32'h200; b.be = 4'b1111; b.we = 1'b0; b.wdata = 32'h0;
      bus_q.push_back(b);
      MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h200;
      repeat (3) @(negedge clk);
      chk("wait_stall", {31'd0, Stall}, 32'd1);
      rst_n = 1'b0; MemRead = 1'b0;
      #1;
      model_rd = '0;
      chk("midrst_stall", {31'd0, Stall}, 32'd0);
      chk("midrst_valid", {31'd0, bus_valid}, 32'd0);
      chk("midrst_addr", bus_addr, 32'd0);
      chk("midrst_be", {28'd0, bus_be}, 32'd0);
      chk("midrst_readdata", ReadData, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("stray_rvalid", ReadData, model_rd);

      chk("bus_q_empty", bus_q.size(), 32'd0);
      chk("comp_q_empty", comp_q.size(), 32'd0);
      chk("plan_q_empty", plan_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
